// File: rtl/uart_pkg.sv
// Shared types, oversampling constants and divisor helper for the UART
// receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } rx_state_t;

    localparam int OVS = 16;

    localparam logic [3:0] SMP_A    = 4'd7;
    localparam logic [3:0] SMP_B    = 4'd8;
    localparam logic [3:0] SMP_C    = 4'd9;
    localparam logic [3:0] OVS_LAST = 4'(OVS - 1);

    // Rounded clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk, input int baud);
        longint den;
        longint q;
        den = longint'(baud) * OVS;
        q   = (longint'(clk) + den / 2) / den;
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO holding received bytes; head is visible
// on dout whenever empty is low.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_nrst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    output logic                  full,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x oversampled 8N1 UART receiver with majority vote and show-ahead FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err output.
module uart_rx_buffered #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 38400,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        sys_clk,
    input  logic                        sys_nrst,
    input  logic                        RX,
    input  logic                        clear,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [7:0]                  rx_data,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        rx_ovf,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err,
`endif
    output logic                        frame_err
);

    import uart_pkg::*;

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic          rx_meta;
    logic          rxs;
    logic          rxs_d;
    rx_state_t     state;
    rx_state_t     state_nx;
    logic [CW-1:0] div_cnt;
    logic [3:0]    ovs_idx;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          smp_a;
    logic          smp_b;
    logic          tick;
    logic          at_smp;
    logic          at_end;
    logic          vote;
    logic          fall;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign fall   = rxs_d & ~rxs;
    assign tick   = (state != IDLE) && (div_cnt == DIV_LAST);
    assign at_smp = tick && (ovs_idx == SMP_C);
    assign at_end = tick && (ovs_idx == OVS_LAST);
    assign vote   = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
    assign pop    = rx_valid & rx_ready;

`ifdef UART_RX_PARITY_EN
    logic par_ok;
    logic par_bad;

    assign par_bad = (^shreg) ^ vote;
    assign push_ok = par_ok;

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            par_ok <= 1'b1;
        end else if (state == PARITY && at_smp) begin
            par_ok <= ~par_bad;
        end
    end
`else
    assign push_ok = 1'b1;
`endif

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_nx = START;
                end
            end
            START: begin
                if (at_smp && vote) begin
                    state_nx = IDLE;
                end else if (at_end) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (at_end && bit_cnt == 3'd7) begin
                    state_nx = AFTER_DATA;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (at_smp) begin
                    parity_err = par_bad;
                end
`endif
                if (at_end) begin
                    state_nx = STOP;
                end
            end
            // Leave at mid stop bit so a slightly fast sender is not missed.
            STOP: begin
                if (at_smp) begin
                    if (vote) begin
                        push     = push_ok;
                        state_nx = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nx  = BRK;
                    end
                end
            end
            BRK: begin
                if (rxs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (clear) begin
            state_nx  = rxs ? IDLE : BRK;
            push      = 1'b0;
            frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err = 1'b0;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            div_cnt <= '0;
            ovs_idx <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
            rx_ovf  <= 1'b0;
        end else begin
            // Idle holds the phase at zero so slot timing starts at the edge.
            if (clear || state == IDLE) begin
                div_cnt <= '0;
                ovs_idx <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                ovs_idx <= ovs_idx + 4'd1;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
            if (tick && ovs_idx == SMP_A) begin
                smp_a <= rxs;
            end
            if (tick && ovs_idx == SMP_B) begin
                smp_b <= rxs;
            end
            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == DATA && at_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == DATA && at_smp) begin
                shreg <= {vote, shreg[7:1]};
            end
            if (clear) begin
                rx_ovf <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                rx_ovf <= 1'b1;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .sys_nrst (sys_nrst),
        .clear    (clear),
        .push     (push),
        .din      (shreg),
        .full     (fifo_full),
        .pop      (pop),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .level    (rx_level)
    );

    assign rx_valid = ~fifo_empty;
    assign rx_data  = rx_valid ? fifo_dout : 8'h00;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: frames are built bit by bit from
// the 8N1 rules and a queue predicts the bytes the consumer must see.
module tb_uart_rx_buffered;

    localparam int CLK_FREQ = 16_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int DEPTH    = 16;
    localparam int BIT      = 16;

    logic       sys_clk  = 1'b0;
    logic       sys_nrst = 1'b0;
    logic       RX       = 1'b1;
    logic       clear    = 1'b0;
    logic       rx_ready = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [4:0] rx_level;
    logic       rx_ovf;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         checks   = 0;
    int         failures = 0;
    int         fe_seen  = 0;
    int         fe_exp   = 0;
    bit         exp_ovf  = 1'b0;
    bit         rand_mode = 1'b0;
    logic [7:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    uart_rx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_nrst  (sys_nrst),
        .RX        (RX),
        .clear     (clear),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_level  (rx_level),
        .rx_ovf    (rx_ovf),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic send_raw(input logic [7:0] d, input bit stop_ok);
        @(posedge sys_clk);
        #1 RX = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(posedge sys_clk);
            #1 RX = d[i];
        end
        repeat (BIT) @(posedge sys_clk);
        #1 RX = stop_ok;
        repeat (BIT) @(posedge sys_clk);
        #1;
    endtask

    // Reference: a good frame lands unless the FIFO is full with no pop.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input bit pop_at_push);
        if (stop_ok) begin
            if (exp_q.size() < DEPTH || pop_at_push) begin
                exp_q.push_back(d);
            end else begin
                exp_ovf = 1'b1;
            end
        end else begin
            fe_exp++;
        end
        send_raw(d, stop_ok);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rx_ready = 1'b1;
        while (exp_q.size() > 0 && n < 4000) begin
            @(posedge sys_clk);
            n++;
        end
        repeat (2) @(posedge sys_clk);
        #1;
        chk("drain_left", exp_q.size(), 0);
        chk("drain_level", rx_level, 0);
    endtask

    task automatic pulse_clear();
        @(posedge sys_clk);
        #1 clear = 1'b1;
        @(posedge sys_clk);
        #1 clear = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge sys_clk);
            if (sys_nrst) begin
                if (frame_err) begin
                    fe_seen++;
                end
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'h0, rx_data}, 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", rx_data, e);
                    end
                end
            end
        end
    end

    initial begin : rand_ready_drv
        forever begin
            @(posedge sys_clk);
            #1;
            if (rand_mode) begin
                rx_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        logic [7:0] d;
        bit ok;

        repeat (4) @(posedge sys_clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_level", rx_level, 0);
        chk("rst_ovf", rx_ovf, 0);
        chk("rst_ferr", frame_err, 0);
        sys_nrst = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;

        // Single byte: latency from start edge and one-cycle valid.
        rx_ready = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                n = 0;
                @(posedge sys_clk);
                #1;
                while (!rx_valid && n < 400) begin
                    @(posedge sys_clk);
                    #1;
                    n++;
                end
                chk("a5_latency", n, 157);
                @(posedge sys_clk);
                #1;
                chk("a5_valid_drop", rx_valid, 0);
            end
        join
        repeat (20) @(posedge sys_clk);
        #1;
        chk("a5_ferr", fe_seen, fe_exp);

        // Start-bit glitch of five clocks.
        @(posedge sys_clk);
        #1 RX = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1 RX = 1'b1;
        repeat (40) @(posedge sys_clk);
        #1;
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_level", rx_level, 0);
        chk("glitch_ferr", fe_seen, fe_exp);
        send_frame(8'h5A, 1'b1, 1'b0);
        drain();

        // Bad stop followed by a long break.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40 * BIT) @(posedge sys_clk);
        #1 RX = 1'b1;
        repeat (32) @(posedge sys_clk);
        #1;
        chk("break_ferr_once", fe_seen, fe_exp);
        chk("break_level", rx_level, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        drain();

        // Overflow: 17 bytes into a 16-entry FIFO with consumer stalled.
        rx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
        end
        repeat (4) @(posedge sys_clk);
        #1;
        chk("ovf_level", rx_level, DEPTH);
        chk("ovf_flag", rx_ovf, exp_ovf);
        chk("ovf_head", rx_data, 8'h00);
        drain();
        chk("ovf_sticky", rx_ovf, 1);
        pulse_clear();
        chk("ovf_cleared", rx_ovf, 0);

        // Full FIFO with a pop landing exactly on the push cycle.
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
        end
        fork
            send_frame(8'h10, 1'b1, 1'b1);
            begin
                @(posedge sys_clk);
                #1;
                repeat (156) @(posedge sys_clk);
                #1;
                chk("full_pre_level", rx_level, DEPTH);
                rx_ready = 1'b1;
                @(posedge sys_clk);
                #1 rx_ready = 1'b0;
                chk("full_pp_level", rx_level, DEPTH);
                chk("full_pp_ovf", rx_ovf, 0);
            end
        join
        drain();
        chk("full_pp_ovf_end", rx_ovf, exp_ovf);

        // clear flushes stored bytes.
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_frame(8'hC0 + 8'(i), 1'b1, 1'b0);
        end
        chk("pre_clear_level", rx_level, 3);
        pulse_clear();
        chk("clear_level", rx_level, 0);
        chk("clear_valid", rx_valid, 0);

        // Reset in the middle of a frame.
        send_frame(8'h11, 1'b1, 1'b0);
        fork
            send_raw(8'h55, 1'b1);
            begin
                repeat (60) @(posedge sys_clk);
                #1 sys_nrst = 1'b0;
                exp_q.delete();
                #2;
                chk("mid_rst_valid", rx_valid, 0);
                chk("mid_rst_data", rx_data, 0);
                chk("mid_rst_level", rx_level, 0);
                chk("mid_rst_ovf", rx_ovf, 0);
                chk("mid_rst_ferr", frame_err, 0);
            end
        join
        repeat (4) @(posedge sys_clk);
        #1 sys_nrst = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        send_frame(8'h66, 1'b1, 1'b0);
        drain();

        // Random bytes, random stop errors, random consumer stalls.
        rand_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok, 1'b0);
            #0 RX = 1'b1;
            repeat (ok ? $urandom_range(0, 20) : $urandom_range(4, 20))
                @(posedge sys_clk);
            #1;
        end
        rand_mode = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2;
        drain();
        chk("rand_ferr", fe_seen, fe_exp);
        chk("rand_ovf", rx_ovf, exp_ovf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
